// File: rtl/password_ctrl_if.sv
// Keypad-password controller port bundle: switch/button inputs and decoder/status outputs.
interface password_ctrl_if;
  logic [3:0] digit_in;
  logic       enter;
  logic       clear;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       unlocked;
  logic       error;
  logic       locked;
  logic [1:0] tries_left;

  modport master (
    output digit_in, enter, clear,
    input  bcd3, bcd2, bcd1, bcd0, unlocked, error, locked, tries_left
  );

  modport slave (
    input  digit_in, enter, clear,
    output bcd3, bcd2, bcd1, bcd0, unlocked, error, locked, tries_left
  );
endinterface

// File: rtl/password_ctrl.sv
// Keypad-password sequencer: collects four BCD digits, compares them against CODE,
// and handles error display and timed lockout after repeated failures.
module password_ctrl #(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          MAX_TRIES   = 3,
  parameter int          SHOW_CYCLES = 50_000_000,
  parameter int          LOCK_CYCLES = 500_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  password_ctrl_if.slave   p
);

  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // One shared timer sized for the longer of the two hold periods.
  localparam int MAXC = (SHOW_CYCLES > LOCK_CYCLES) ? SHOW_CYCLES : LOCK_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] SHOW_END = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_END = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    TRIES0   = 2'(MAX_TRIES);

  logic [2:0]    state;
  logic [15:0]   code_buf;   // doubles as the four decoder nibbles
  logic [2:0]    cnt;
  logic [TW-1:0] timer;
  logic [1:0]    tries_left;
  logic          unlocked, error, locked;
  logic          enter_q, clear_q;
  logic          enter_pe, clear_pe;

  // Presses are rising edges against the registered copy; copies reset high so a
  // button held through reset has to be released before it registers.
  assign enter_pe = p.enter & ~enter_q;
  assign clear_pe = p.clear & ~clear_q;

  assign p.bcd3       = code_buf[15:12];
  assign p.bcd2       = code_buf[11:8];
  assign p.bcd1       = code_buf[7:4];
  assign p.bcd0       = code_buf[3:0];
  assign p.unlocked   = unlocked;
  assign p.error      = error;
  assign p.locked     = locked;
  assign p.tries_left = tries_left;

  // Button edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_q <= 1'b1;
      clear_q <= 1'b1;
    end else begin
      enter_q <= p.enter;
      clear_q <= p.clear;
    end
  end

  // Main sequencer: state, entry buffer, timer, failure tracking and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ENTRY;
      code_buf   <= 16'hFFFF;
      cnt        <= 3'd0;
      timer      <= '0;
      tries_left <= TRIES0;
      unlocked   <= 1'b0;
      error      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      case (state)
        ST_ENTRY: begin
          // Clear beats a simultaneous enter; non-decimal digits are dropped.
          if (clear_pe) begin
            code_buf <= 16'hFFFF;
            cnt      <= 3'd0;
          end else if (enter_pe && (p.digit_in <= 4'd9)) begin
            code_buf <= {code_buf[11:0], p.digit_in};
            cnt      <= cnt + 3'd1;
            if (cnt == 3'd3) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          cnt <= 3'd0;
          if (code_buf == CODE) begin
            state      <= ST_OPEN;
            unlocked   <= 1'b1;
            tries_left <= TRIES0;
          end else if (tries_left <= 2'd1) begin
            state      <= ST_LOCKOUT;
            locked     <= 1'b1;
            tries_left <= 2'd0;
            code_buf   <= 16'hAAAA;
            timer      <= '0;
          end else begin
            state      <= ST_FAIL;
            error      <= 1'b1;
            tries_left <= tries_left - 2'd1;
            code_buf   <= 16'hFFFF;
            timer      <= '0;
          end
        end
        ST_OPEN: begin
          if (clear_pe) begin
            state    <= ST_ENTRY;
            unlocked <= 1'b0;
            code_buf <= 16'hFFFF;
          end
        end
        ST_FAIL: begin
          if (timer == SHOW_END) begin
            state    <= ST_ENTRY;
            error    <= 1'b0;
            code_buf <= 16'hFFFF;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_LOCKOUT: begin
          if (timer == LOCK_END) begin
            state      <= ST_ENTRY;
            locked     <= 1'b0;
            tries_left <= TRIES0;
            code_buf   <= 16'hFFFF;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= ST_ENTRY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_password_ctrl.sv
// Directed bench for password_ctrl: cycle table for entry/filtering, plus
// hand-written sequences for FAIL timing, lockout and asynchronous reset.
module tb_password_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  password_ctrl_if pif();

  password_ctrl #(
    .CODE(16'h1234), .MAX_TRIES(3), .SHOW_CYCLES(8), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .p(pif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e;
    logic        c;
    logic [3:0]  d;
    logic [15:0] bcd;
    logic        u;
    logic        er;
    logic        lk;
    logic [1:0]  tl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd_now();
    return {pif.bcd3, pif.bcd2, pif.bcd1, pif.bcd0};
  endfunction

  task automatic chk_all(input string nm, input logic [15:0] bcd, input logic u,
                         input logic er, input logic lk, input logic [1:0] tl);
    chk({nm, ".bcd"}, 32'(bcd_now()), 32'(bcd));
    chk({nm, ".flags"}, {29'd0, pif.unlocked, pif.error, pif.locked}, {29'd0, u, er, lk});
    chk({nm, ".tries"}, 32'(pif.tries_left), 32'(tl));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One press: enter high across one edge, then dropped at the following negedge.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    pif.enter    = 1'b1;
    pif.digit_in = d;
    step();
    @(negedge clk);
    pif.enter = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
  endtask

  // Bounded wait for the FSM to leave FAIL/LOCKOUT.
  task automatic wait_idle();
    int n = 0;
    while ((pif.error || pif.locked) && n < 60) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic add(input logic e, input logic c, input logic [3:0] d, input logic [15:0] b,
                     input logic u, input logic [1:0] tl);
    tbl.push_back('{e, c, d, b, u, 1'b0, 1'b0, tl});
  endtask

  initial begin
    pif.enter = 1'b0; pif.clear = 1'b0; pif.digit_in = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_all("reset", 16'hFFFF, 0, 0, 0, 2'd3);
    @(negedge clk) rst_n = 1'b1;

    // Per-cycle vectors: entry, filtering, held enter, correct code, open, clear races
    add(0, 0, 4'h0, 16'hFFFF, 0, 3);
    add(1, 0, 4'h1, 16'hFFF1, 0, 3);
    add(0, 0, 4'h1, 16'hFFF1, 0, 3);
    add(1, 0, 4'h2, 16'hFF12, 0, 3);
    add(0, 0, 4'h2, 16'hFF12, 0, 3);
    add(1, 0, 4'hB, 16'hFF12, 0, 3);   // non-decimal digit ignored
    add(0, 0, 4'hB, 16'hFF12, 0, 3);
    add(1, 0, 4'h3, 16'hF123, 0, 3);   // held for 10 cycles -> one capture
    for (int i = 0; i < 9; i++) add(1, 0, 4'h7, 16'hF123, 0, 3);
    add(0, 0, 4'h7, 16'hF123, 0, 3);
    add(1, 0, 4'h4, 16'h1234, 0, 3);   // 4th digit; CHECK this cycle
    add(0, 0, 4'h4, 16'h1234, 1, 3);   // OPEN
    add(1, 0, 4'h5, 16'h1234, 1, 3);   // enter ignored while open
    add(0, 0, 4'h5, 16'h1234, 1, 3);
    add(0, 1, 4'h5, 16'hFFFF, 0, 3);   // clear relocks
    add(0, 0, 4'h5, 16'hFFFF, 0, 3);
    add(1, 0, 4'h1, 16'hFFF1, 0, 3);
    add(0, 0, 4'h1, 16'hFFF1, 0, 3);
    add(1, 0, 4'h2, 16'hFF12, 0, 3);
    add(0, 0, 4'h2, 16'hFF12, 0, 3);
    add(1, 1, 4'h3, 16'hFFFF, 0, 3);   // clear wins over enter
    add(0, 0, 4'h3, 16'hFFFF, 0, 3);

    foreach (tbl[i]) begin
      @(negedge clk);
      pif.enter = tbl[i].e; pif.clear = tbl[i].c; pif.digit_in = tbl[i].d;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].u, tbl[i].er, tbl[i].lk, tbl[i].tl);
    end
    @(negedge clk);
    pif.enter = 1'b0; pif.clear = 1'b0;

    // Wrong code: count restarted at 0, so exactly four more digits reach CHECK
    enter_code(16'h1235);
    chk_all("wrong.4th", 16'h1235, 0, 0, 0, 2'd3);
    step();
    chk_all("wrong.fail", 16'hFFFF, 0, 1, 0, 2'd2);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("wrong.err%0d", i), 32'(pif.error), 32'd1);
    end
    step();
    chk_all("wrong.exit", 16'hFFFF, 0, 0, 0, 2'd2);
    press(4'h7);
    chk("wrong.reentry", 32'(bcd_now()), 32'hFFF7);
    @(negedge clk) pif.clear = 1'b1;
    @(negedge clk) pif.clear = 1'b0;

    // Lockout: second and third failures
    enter_code(16'h9999);
    step();
    chk("lock.fail2.tries", 32'(pif.tries_left), 32'd1);
    wait_idle();
    enter_code(16'h0000);
    step();
    chk_all("lock.enter", 16'hAAAA, 0, 0, 1, 2'd0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      pif.enter = (i < 10) ? i[0] : 1'b0;
      pif.digit_in = 4'h1;
      step();
      chk($sformatf("lock.hold%0d", i), {15'd0, pif.locked, bcd_now()}, {15'd0, 1'b1, 16'hAAAA});
    end
    step();
    chk_all("lock.exit", 16'hFFFF, 0, 0, 0, 2'd3);

    // Async reset mid-entry, between edges
    press(4'h5); press(4'h6);
    chk("arst.pre", 32'(bcd_now()), 32'hFF56);
    #2 rst_n = 1'b0;
    #1 chk_all("arst.entry", 16'hFFFF, 0, 0, 0, 2'd3);
    @(negedge clk) rst_n = 1'b1;

    // Async reset during lockout
    enter_code(16'h1111); step(); wait_idle();
    enter_code(16'h2222); step(); wait_idle();
    enter_code(16'h3333); step();
    chk("arst.locked", 32'(pif.locked), 32'd1);
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk_all("arst.lockout", 16'hFFFF, 0, 0, 0, 2'd3);
    @(negedge clk) rst_n = 1'b1;

    // Failure count discarded by reset: one wrong code is only a FAIL
    enter_code(16'h4444);
    step();
    chk_all("arst.tries", 16'hFFFF, 0, 1, 0, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
